// File: rtl/bist_pkg.sv
// Shared definitions for the adder BIST response analyzer: FSM encoding,
// MISR geometry and the fault-free full-adder reference.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MISR_W = 8;

  // Feedback taps x^8 + x^6 + x^5 + x^4 + 1: bits 7, 5, 4 and 3 of the state.
  localparam logic [MISR_W-1:0] MISR_TAPS = 8'hB8;

  // Fault-free full adder, pattern = {a,b,cin}, result = {sum,cout}.
  function automatic logic [1:0] fa_golden(input logic [2:0] p);
    logic a;
    logic b;
    logic c;
    a = p[2];
    b = p[1];
    c = p[0];
    return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
  endfunction

endpackage

// File: rtl/misr8.sv
// 8-bit multiple-input signature register compacting a 2-bit response.
// load restarts from SEED and wins over enable; enable folds in din.
module misr8
  import bist_pkg::*;
#(
  parameter logic [MISR_W-1:0] SEED = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              enable,
  input  logic [1:0]        din,
  output logic [MISR_W-1:0] sig
);

  logic fb;

  assign fb = ^(sig & MISR_TAPS);

  // Shift with XOR feedback, response injected into the two low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (enable) begin
      sig <= {sig[MISR_W-2:0], fb} ^ {{(MISR_W-2){1'b0}}, din};
    end
  end

endmodule

// File: rtl/response_analyzer.sv
// BIST response analyzer for a full-adder CUT: compacts responses into a
// MISR, compares each response against the reference adder, and issues a
// pass/fail verdict after N_PATTERNS accepted patterns.
//
// Input handshake: there is no ready; a pattern is consumed on every rising
// edge where pattern_valid=1 while the FSM is in RUN and abort=0. Valid
// cycles outside RUN are dropped silently.
module response_analyzer
  import bist_pkg::*;
#(
  parameter int          N_PATTERNS = 8,
  parameter logic [7:0]  MISR_SEED  = 8'hFF,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pattern_valid,
  input  logic [2:0] pattern,
  input  logic [1:0] dataIn,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [7:0] err_count,
  output logic [7:0] first_fail,
  output state_e     fsm_state
);

  localparam logic [7:0] LAST_IDX = 8'(N_PATTERNS - 1);

  state_e     state;
  logic [7:0] cnt;
  logic       start_ok;
  logic       accept;
  logic       mismatch;

  assign start_ok  = start && !abort && (state == ST_IDLE || state == ST_DONE);
  assign accept    = pattern_valid && !abort && (state == ST_RUN);
  assign mismatch  = accept && (dataIn != fa_golden(pattern));
  assign fsm_state = state;

  misr8 #(
    .SEED (MISR_SEED)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_ok),
    .enable (accept),
    .din    (dataIn),
    .sig    (signature)
  );

  // Control FSM with registered status outputs; abort overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      err_count  <= 8'd0;
      first_fail <= 8'hFF;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RUN;
            cnt        <= 8'd0;
            err_count  <= 8'd0;
            first_fail <= 8'hFF;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pattern_valid) begin
            cnt <= cnt + 8'd1;
            if (mismatch) begin
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              // first_fail still at its sentinel means no earlier miss
              if (first_fail == 8'hFF) first_fail <= cnt;
            end
            if (cnt == LAST_IDX) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          pass  <= (signature == GOLDEN_SIG) && (err_count == 8'd0);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
